// File: rtl/kilit_pkg.sv
// kilit_pkg: shared widths, state codes and helpers for the combination-lock controller.
package kilit_pkg;

    localparam int KOD_W      = 6;
    localparam int HATA_W     = 4;
    localparam int KOD_CARPAN = 5;

    localparam logic [1:0] BEKLE   = 2'd0;
    localparam logic [1:0] KONTROL = 2'd1;
    localparam logic [1:0] ACIK    = 2'd2;
    localparam logic [1:0] CEZA    = 2'd3;

    function automatic int enbuyuk(input int a, input int b);
        return a > b ? a : b;
    endfunction

endpackage

// File: rtl/kilit_denetleyici_if.sv
// kilit_denetleyici_if: attempt handshake, lock status and password-write bus of the lock controller.
interface kilit_denetleyici_if;
    import kilit_pkg::*;

    logic              deneme_gecerli;
    logic [2:0]        sag_adim;
    logic [1:0]        sol_adim;
    logic              hazir;
    logic              kilit_acik;
    logic              ceza_aktif;
    logic [HATA_W-1:0] hata_sayisi;
    logic              kilitle;
    logic              sifre_yaz;
    logic [KOD_W-1:0]  yeni_sifre;

    modport master (
        output deneme_gecerli, sag_adim, sol_adim, kilitle, sifre_yaz, yeni_sifre,
        input  hazir, kilit_acik, ceza_aktif, hata_sayisi
    );

    modport slave (
        input  deneme_gecerli, sag_adim, sol_adim, kilitle, sifre_yaz, yeni_sifre,
        output hazir, kilit_acik, ceza_aktif, hata_sayisi
    );

endinterface

// File: rtl/kilit_denetleyici_kod_hesapla.sv
// kod_hesapla: combinational lock code, 5 * ((sag - 2*sol) mod 8).
module kod_hesapla
    import kilit_pkg::*;
(
    input  logic [2:0]       sag_i,
    input  logic [1:0]       sol_i,
    output logic [KOD_W-1:0] kod_o
);

    logic [2:0] fark;

    assign fark  = sag_i - {sol_i, 1'b0};
    assign kod_o = KOD_W'(fark) * KOD_W'(KOD_CARPAN);

endmodule

// File: rtl/kilit_denetleyici.sv
// kilit_denetleyici: attempt check, open window, failure count and lockout for the combination lock.
// KILIT_OTOMATIK_KAPAMA_EN defined: the open lock closes itself after ACIK_SURE cycles.
module kilit_denetleyici
    import kilit_pkg::*;
#(
    parameter int               MAX_HATA         = 3,
    parameter int               ACIK_SURE        = 16,
    parameter int               CEZA_SURE        = 64,
    parameter logic [KOD_W-1:0] VARSAYILAN_SIFRE = 6'd15
) (
    input logic                clk,
    input logic                rst_n,
    kilit_denetleyici_if.slave bus
);

    localparam int TW = $clog2(enbuyuk(ACIK_SURE, CEZA_SURE) + 1);

    logic [1:0]        durum_q, durum_d;
    logic [TW-1:0]     sayac_q, sayac_d;
    logic [HATA_W-1:0] hata_q, hata_d;
    logic [KOD_W-1:0]  sifre_q, sifre_d;
    logic [2:0]        sag_q, sag_d;
    logic [1:0]        sol_q, sol_d;
    logic              hazir_q, acik_q, ceza_q;
    logic [HATA_W-1:0] hata_cikis_q;
    logic [KOD_W-1:0]  kod;
    logic              kabul;

    kod_hesapla u_kod (
        .sag_i (sag_q),
        .sol_i (sol_q),
        .kod_o (kod)
    );

    assign kabul = bus.deneme_gecerli && hazir_q;

    always_comb begin
        durum_d = durum_q;
        sayac_d = sayac_q;
        hata_d  = hata_q;
        sifre_d = sifre_q;
        sag_d   = sag_q;
        sol_d   = sol_q;
        case (durum_q)
            BEKLE: begin
                if (kabul) begin
                    durum_d = KONTROL;
                    sag_d   = bus.sag_adim;
                    sol_d   = bus.sol_adim;
                end
            end
            KONTROL: begin
                if (kod == sifre_q) begin
                    durum_d = ACIK;
                    hata_d  = '0;
`ifdef KILIT_OTOMATIK_KAPAMA_EN
                    sayac_d = TW'(ACIK_SURE - 1);
`endif
                end else if (hata_q + HATA_W'(1) == HATA_W'(MAX_HATA)) begin
                    durum_d = CEZA;
                    hata_d  = HATA_W'(MAX_HATA);
                    sayac_d = TW'(CEZA_SURE - 1);
                end else begin
                    durum_d = BEKLE;
                    hata_d  = hata_q + HATA_W'(1);
                end
            end
            ACIK: begin
                sifre_d = bus.sifre_yaz ? bus.yeni_sifre : sifre_q;
`ifdef KILIT_OTOMATIK_KAPAMA_EN
                sayac_d = sayac_q == '0 ? '0 : sayac_q - TW'(1);
                durum_d = bus.kilitle || sayac_q == '0 ? BEKLE : ACIK;
`else
                durum_d = bus.kilitle ? BEKLE : ACIK;
`endif
            end
            default: begin
                sayac_d = sayac_q == '0 ? '0 : sayac_q - TW'(1);
                durum_d = sayac_q == '0 ? BEKLE : CEZA;
                hata_d  = sayac_q == '0 ? '0 : hata_q;
            end
        endcase
    end

    // Status outputs are a registered decode of the current state, one cycle behind it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            durum_q      <= BEKLE;
            sayac_q      <= '0;
            hata_q       <= '0;
            sifre_q      <= VARSAYILAN_SIFRE;
            sag_q        <= '0;
            sol_q        <= '0;
            hazir_q      <= 1'b1;
            acik_q       <= 1'b0;
            ceza_q       <= 1'b0;
            hata_cikis_q <= '0;
        end else begin
            durum_q      <= durum_d;
            sayac_q      <= sayac_d;
            hata_q       <= hata_d;
            sifre_q      <= sifre_d;
            sag_q        <= sag_d;
            sol_q        <= sol_d;
            hazir_q      <= durum_q == BEKLE && !kabul;
            acik_q       <= durum_q == ACIK;
            ceza_q       <= durum_q == CEZA;
            hata_cikis_q <= hata_q;
        end
    end

    assign bus.hazir       = hazir_q;
    assign bus.kilit_acik  = acik_q;
    assign bus.ceza_aktif  = ceza_q;
    assign bus.hata_sayisi = hata_cikis_q;

endmodule
